// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ARB_AW_DEF = 32;
    localparam int ARB_DW_DEF = 32;

    // Owner of the in-flight memory transaction
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Requester identity, also the encoding of grant/last-grant bits
    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle distributed to pipeline-side blocks.
// Latency: n/a (wiring only).
// Backpressure: n/a.
interface ctrl_bus_if;
    logic clk;
    logic reset;

    modport central (
        input clk,
        input reset
    );
endinterface

// File: rtl/arb_pick.sv
// Two-way grant selector between fetch and memory stage (ARB_RR_EN: alternate on contention).
// Latency: purely combinational.
// Backpressure: none; grant valid whenever any requester is eligible.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic f_elig,
    input  logic d_elig,
`ifdef ARB_RR_EN
    input  logic last_gnt,   // req_id_e encoding of the previous winner
`endif
    output logic gnt_vld,
    output logic gnt_id      // req_id_e encoding of the winner
);

    // Pick the winner; memory stage has priority unless alternating on contention
    always_comb begin
        gnt_vld = f_elig | d_elig;
        gnt_id  = REQ_F;
        if (d_elig && !f_elig) begin
            gnt_id = REQ_D;
        end else if (d_elig && f_elig) begin
`ifdef ARB_RR_EN
            // The requester that did not win last time goes first
            gnt_id = (last_gnt == REQ_F) ? REQ_D : REQ_F;
`else
            gnt_id = REQ_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one single-ported memory between fetch and memory stage; optional ARB_RR_EN alternates on contention.
// Latency: request to done minimum 2 cycles (m_req next cycle, done the cycle after m_ack); back-to-back grants chain on m_ack.
// Backpressure: requesters hold X_req until X_done and see X_stall meanwhile; memory side holds m_* until m_ack.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW_DEF,
    parameter int DW = ARB_DW_DEF
)
(
    ctrl_bus_if.central     ctrl_bus,
    input  logic            f_req,
    input  logic [AW-1:0]   f_addr,
    output logic [DW-1:0]   f_rdata,
    output logic            f_done,
    output logic            f_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_stall,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack
);

    logic clk;
    logic reset;
    assign clk   = ctrl_bus.clk;
    assign reset = ctrl_bus.reset;

    arb_state_e     state_q, state_d;
    logic           m_req_q, m_req_d;
    logic           m_we_q, m_we_d;
    logic [AW-1:0]  m_addr_q, m_addr_d;
    logic [DW-1:0]  m_wdata_q, m_wdata_d;
    logic           f_done_q, f_done_d;
    logic           d_done_q, d_done_d;
    logic [DW-1:0]  f_rdata_q, f_rdata_d;
    logic [DW-1:0]  d_rdata_q, d_rdata_d;
`ifdef ARB_RR_EN
    logic           last_gnt_q, last_gnt_d;
`endif

    logic           ack_f;
    logic           ack_d;
    logic           decide;
    logic           f_elig;
    logic           d_elig;
    logic           gnt_vld;
    logic           gnt_id;

    // Completion, decision point and eligibility; the owner and a requester in its done cycle are excluded
    always_comb begin
        ack_f  = (state_q == BUSY_F) && m_ack;
        ack_d  = (state_q == BUSY_D) && m_ack;
        decide = (state_q == IDLE) || ack_f || ack_d;
        f_elig = f_req && (state_q != BUSY_F) && !f_done_q;
        d_elig = d_req && (state_q != BUSY_D) && !d_done_q;
    end

    arb_pick u_pick (
        .f_elig   (f_elig),
        .d_elig   (d_elig),
`ifdef ARB_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next owner: re-evaluated in IDLE and on the completing m_ack so grants chain without a bubble
    always_comb begin
        state_d = state_q;
        if (decide) begin
            if (!gnt_vld) begin
                state_d = IDLE;
            end else if (gnt_id == REQ_D) begin
                state_d = BUSY_D;
            end else begin
                state_d = BUSY_F;
            end
        end
    end

    // Next memory command, done pulses and read-data capture
    always_comb begin
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        f_done_d  = ack_f;
        d_done_d  = ack_d;
        f_rdata_d = ack_f ? m_rdata : f_rdata_q;
        // A completed write leaves the last read value in place
        d_rdata_d = (ack_d && !m_we_q) ? m_rdata : d_rdata_q;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        if (decide) begin
            m_req_d = gnt_vld;
            if (gnt_vld) begin
                if (gnt_id == REQ_D) begin
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else begin
                    m_we_d    = 1'b0;
                    m_addr_d  = f_addr;
                    m_wdata_d = '0;
                end
`ifdef ARB_RR_EN
                last_gnt_d = gnt_id;
`endif
            end
        end
    end

    // Datapath registers; m_* only change at a decision point so they hold while waiting for m_ack
    always_ff @(posedge clk) begin
        if (reset) begin
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            f_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_RR_EN
            last_gnt_q <= REQ_F;
`endif
        end else begin
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            f_done_q   <= f_done_d;
            d_done_q   <= d_done_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign f_done  = f_done_q;
    assign d_done  = d_done_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

    // Stalls hold the requesting stage until its done pulse
    assign f_stall = f_req & ~f_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: stimulus pushes expected memory commands and
// done responses; one negedge process plays the memory and pops/compares.
module tb_mem_port_arb;

    ctrl_bus_if cb ();

    logic        f_req   = 1'b0;
    logic [31:0] f_addr  = '0;
    logic [31:0] f_rdata;
    logic        f_done;
    logic        f_stall;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [31:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack   = 1'b0;

    mem_port_arb dut (
        .ctrl_bus (cb),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_rdata  (f_rdata),
        .f_done   (f_done),
        .f_stall  (f_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_stall  (d_stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          start;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          at;
    } rsp_t;

    txn_t exp_txn[$];
    rsp_t exp_f[$];
    rsp_t exp_d[$];
    int   exp_idle[$];

    int   cyc           = 0;
    int   checks        = 0;
    int   errors        = 0;
    int   ack_k         = 0;
    int   force_ack_cyc = -1;
    logic hold_ack      = 1'b0;
    logic mon_en        = 1'b0;
    logic end_chk       = 1'b0;
    logic end_done      = 1'b0;

    // responder state
    logic        in_txn   = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] s_addr   = '0;
    logic        s_we     = 1'b0;
    logic [31:0] s_wdata  = '0;

    initial begin
        cb.clk = 1'b0;
        forever #5 cb.clk = ~cb.clk;
    end

    always @(posedge cb.clk) cyc <= cyc + 1;

    // Memory contents seen by reads
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0051_3023;
            32'h0000_0014: return 32'h00A0_0093;
            32'h0000_0018: return 32'h0010_8113;
            32'h0000_0030: return 32'h0000_0013;
            32'h0000_0100: return 32'h1234_5678;
            32'h0000_0300: return 32'h0BAD_F00D;
            32'h0000_0304: return 32'h1357_9BDF;
            default:       return 32'hEEEE_EEEE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic we, input logic [31:0] wd, input int st);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = wd; t.start = st;
        exp_txn.push_back(t);
    endtask

    task automatic push_f(input logic [31:0] data, input int at);
        rsp_t r;
        r.data = data; r.at = at;
        exp_f.push_back(r);
    endtask

    task automatic push_d(input logic [31:0] data, input int at);
        rsp_t r;
        r.data = data; r.at = at;
        exp_d.push_back(r);
    endtask

    // Fetch requester: hold until done; keep=1 leaves f_req high for a follow-on request
    task automatic fetch_op(input logic [31:0] a, input logic keep);
        f_req  = 1'b1;
        f_addr = a;
        do @(negedge cb.clk); while (f_done !== 1'b1);
        @(posedge cb.clk); #1;
        if (!keep) f_req = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        do @(negedge cb.clk); while (d_done !== 1'b1);
        @(posedge cb.clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    // Monitor and memory model: all comparisons happen here, away from the active edge
    always @(negedge cb.clk) begin
        txn_t tx;
        rsp_t rr;
        if (cyc > 3000) begin
            errors++;
            $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "watchdog expired");
        end
        if (m_ack) begin
            m_ack  = 1'b0;
            in_txn = 1'b0;
        end
        if (mon_en) begin
            if (exp_idle.size() != 0 && exp_idle[0] == cyc) begin
                void'(exp_idle.pop_front());
                chk("idle_m_req",   m_req,   32'h0);
                chk("idle_m_we",    m_we,    32'h0);
                chk("idle_m_addr",  m_addr,  32'h0);
                chk("idle_m_wdata", m_wdata, 32'h0);
                chk("idle_f_done",  f_done,  32'h0);
                chk("idle_d_done",  d_done,  32'h0);
                chk("idle_f_rdata", f_rdata, 32'h0);
                chk("idle_d_rdata", d_rdata, 32'h0);
            end
            chk("f_stall", f_stall, f_req && !f_done);
            chk("d_stall", d_stall, d_req && !d_done);
            if (f_done === 1'b1) begin
                if (exp_f.size() == 0) begin
                    chk("f_done_unexpected", f_done, 32'h0);
                end else begin
                    rr = exp_f.pop_front();
                    chk("f_rdata", f_rdata, rr.data);
                    chk("f_done_cycle", cyc, rr.at);
                end
            end
            if (d_done === 1'b1) begin
                if (exp_d.size() == 0) begin
                    chk("d_done_unexpected", d_done, 32'h0);
                end else begin
                    rr = exp_d.pop_front();
                    chk("d_rdata", d_rdata, rr.data);
                    chk("d_done_cycle", cyc, rr.at);
                end
            end
            if (cyc == force_ack_cyc) begin
                m_ack   = 1'b1;
                m_rdata = 32'h5555_AAAA;
            end else if (cb.reset || hold_ack) begin
                in_txn = 1'b0;
            end else if (m_req === 1'b1) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                    s_addr   = m_addr;
                    s_we     = m_we;
                    s_wdata  = m_wdata;
                    if (exp_txn.size() == 0) begin
                        chk("m_req_unexpected", m_req, 32'h0);
                    end else begin
                        tx = exp_txn.pop_front();
                        chk("m_addr",      m_addr,  tx.addr);
                        chk("m_we",        m_we,    tx.we);
                        chk("m_wdata",     m_wdata, tx.wdata);
                        chk("m_req_cycle", cyc,     tx.start);
                    end
                end else begin
                    chk("m_addr_hold",  m_addr,  s_addr);
                    chk("m_we_hold",    m_we,    s_we);
                    chk("m_wdata_hold", m_wdata, s_wdata);
                end
                if (wait_cnt >= ack_k) begin
                    m_ack   = 1'b1;
                    m_rdata = s_we ? 32'hFFFF_FFFF : mem_rd(s_addr);
                end else begin
                    wait_cnt++;
                end
            end
            if (end_chk && !end_done) begin
                end_done = 1'b1;
                chk("left_txn",  exp_txn.size(),  32'h0);
                chk("left_f",    exp_f.size(),    32'h0);
                chk("left_d",    exp_d.size(),    32'h0);
                chk("left_idle", exp_idle.size(), 32'h0);
            end
        end
    end

    initial begin
        int t0;
        int t1;
        cb.reset = 1'b1;
        repeat (3) @(posedge cb.clk);
        #1;
        cb.reset = 1'b0;
        mon_en   = 1'b1;
        exp_idle.push_back(cyc);

        // Fetch alone, ack in the first m_req cycle
        ack_k = 0;
        @(posedge cb.clk); #1;
        t0 = cyc;
        push_txn(32'h10, 1'b0, 32'h0, t0 + 1);
        push_f(32'h0051_3023, t0 + 2);
        fetch_op(32'h10, 1'b0);

        // Read and fetch raised together: data first, fetch chained on its ack
        ack_k = 2;
        @(posedge cb.clk); #1;
        t0 = cyc;
        push_txn(32'h100, 1'b0, 32'h0, t0 + 1);
        push_txn(32'h14,  1'b0, 32'h0, t0 + 4);
        push_d(32'h1234_5678, t0 + 4);
        push_f(32'h00A0_0093, t0 + 7);
        fork
            fetch_op(32'h14, 1'b0);
            data_op(1'b0, 32'h100, 32'h0);
        join

        // Write: d_rdata keeps the previous read value
        ack_k = 1;
        @(posedge cb.clk); #1;
        t0 = cyc;
        push_txn(32'h200, 1'b1, 32'hDEAD_BEEF, t0 + 1);
        push_d(32'h1234_5678, t0 + 3);
        data_op(1'b1, 32'h200, 32'hDEAD_BEEF);

        // Fetch held across done with a new address: no repeat of 0x14
        @(posedge cb.clk); #1;
        t0 = cyc;
        push_txn(32'h14, 1'b0, 32'h0, t0 + 1);
        push_f(32'h00A0_0093, t0 + 3);
        push_txn(32'h18, 1'b0, 32'h0, t0 + 5);
        push_f(32'h0010_8113, t0 + 7);
        fetch_op(32'h14, 1'b1);
        fetch_op(32'h18, 1'b0);

        // Data alone, then contention right after a data grant
        @(posedge cb.clk); #1;
        t0 = cyc;
        push_txn(32'h300, 1'b0, 32'h0, t0 + 1);
        push_d(32'h0BAD_F00D, t0 + 3);
        data_op(1'b0, 32'h300, 32'h0);
        @(posedge cb.clk); #1;
        t1 = cyc;
`ifdef ARB_RR_EN
        push_txn(32'h30,  1'b0, 32'h0, t1 + 1);
        push_txn(32'h304, 1'b0, 32'h0, t1 + 3);
        push_f(32'h0000_0013, t1 + 3);
        push_d(32'h1357_9BDF, t1 + 5);
`else
        push_txn(32'h304, 1'b0, 32'h0, t1 + 1);
        push_txn(32'h30,  1'b0, 32'h0, t1 + 3);
        push_d(32'h1357_9BDF, t1 + 3);
        push_f(32'h0000_0013, t1 + 5);
`endif
        fork
            fetch_op(32'h30, 1'b0);
            data_op(1'b0, 32'h304, 32'h0);
        join

        // Reset while a fetch waits for m_ack; late ack must be ignored
        hold_ack = 1'b1;
        @(posedge cb.clk); #1;
        t0 = cyc;
        f_req  = 1'b1;
        f_addr = 32'h20;
        @(posedge cb.clk); #1;
        cb.reset      = 1'b1;
        f_req         = 1'b0;
        force_ack_cyc = t0 + 2;
        exp_idle.push_back(t0 + 2);
        exp_idle.push_back(t0 + 3);
        exp_idle.push_back(t0 + 4);
        @(posedge cb.clk); #1;
        cb.reset = 1'b0;
        repeat (3) @(posedge cb.clk);
        #1;
        hold_ack = 1'b0;

        end_chk = 1'b1;
        repeat (3) @(posedge cb.clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
